// File: rtl/bfly_seq.sv
// bfly_seq: control sequencer for one shared radix-2 butterfly running an
// in-place decimation-in-time FFT. Walks every stage and butterfly, issues one
// read pair plus twiddle index per cycle, and replays the addresses LAT cycles
// later as the write-back strobe. Drain cycles between stages keep a stage from
// reading results that are still in flight. No sample data passes through here.
`timescale 1ns/1ps
module bfly_seq #(
  parameter int N       = 4,  // butterfly data width is 2**N (datapath only)
  parameter int LOG2PTS = 3,  // log2 of FFT size
  parameter int LAT     = 2   // rd_en to write-port latency
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               busy,
  output logic               done,
  output logic [LOG2PTS-1:0] stage,
  output logic               rd_en,
  output logic [LOG2PTS-1:0] rd_addr_a,
  output logic [LOG2PTS-1:0] rd_addr_b,
  output logic [LOG2PTS-2:0] tw_idx,
  output logic               wr_en,
  output logic [LOG2PTS-1:0] wr_addr_a,
  output logic [LOG2PTS-1:0] wr_addr_b
);

  localparam int K_W = LOG2PTS - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  if (N < 1 || LOG2PTS < 2 || LOG2PTS > 8 || LAT < 1 || LAT > 8) begin : g_param_err
    $error("bfly_seq: parameter out of legal range");
  end

  logic [1:0]     state;
  logic [K_W-1:0] k;
  logic [3:0]     drain_cnt;

  logic                wr_vld_p [LAT];
  logic [LOG2PTS-1:0]  wr_a_p   [LAT];
  logic [LOG2PTS-1:0]  wr_b_p   [LAT];

  // Top operand address: group index shifted past the pair span, plus position.
  function automatic logic [LOG2PTS-1:0] addr_top(input logic [LOG2PTS-1:0] s,
                                                  input logic [K_W-1:0] kk);
    logic [LOG2PTS-1:0] kx, mask, pos, grp;
    kx   = {1'b0, kk};
    mask = (LOG2PTS'(1) << s) - LOG2PTS'(1);
    pos  = kx & mask;
    grp  = kx >> s;
    return (grp << (s + LOG2PTS'(1))) | pos;
  endfunction

  // Bottom operand sits one span above the top operand.
  function automatic logic [LOG2PTS-1:0] addr_bot(input logic [LOG2PTS-1:0] s,
                                                  input logic [K_W-1:0] kk);
    return addr_top(s, kk) + (LOG2PTS'(1) << s);
  endfunction

  // Twiddle index: position within the group scaled to the full ROM range.
  function automatic logic [K_W-1:0] twiddle(input logic [LOG2PTS-1:0] s,
                                             input logic [K_W-1:0] kk);
    logic [LOG2PTS-1:0] kx, mask, pos, shamt;
    kx    = {1'b0, kk};
    mask  = (LOG2PTS'(1) << s) - LOG2PTS'(1);
    pos   = kx & mask;
    shamt = LOG2PTS'(LOG2PTS - 1) - s;
    return K_W'(pos << shamt);
  endfunction

  // Sequencing FSM and registered issue outputs (p0 of the write delay line).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      k         <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
    end else begin
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      busy      <= (state == S_ISSUE) || (state == S_DRAIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ISSUE;
            stage <= '0;
            k     <= '0;
          end
        end
        S_ISSUE: begin
          if (!hold) begin
            rd_en     <= 1'b1;
            rd_addr_a <= addr_top(stage, k);
            rd_addr_b <= addr_bot(stage, k);
            tw_idx    <= twiddle(stage, k);
            k         <= k + K_W'(1);
            if (&k) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 4'(LAT - 1)) begin
            if (stage == LOG2PTS'(LOG2PTS - 1)) begin
              state <= S_DONE;
            end else begin
              stage <= stage + LOG2PTS'(1);
              k     <= '0;
              state <= S_ISSUE;
            end
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        default: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back delay line: free-running, carries the issued pair LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        wr_vld_p[i] <= 1'b0;
        wr_a_p[i]   <= '0;
        wr_b_p[i]   <= '0;
      end
    end else begin
      wr_vld_p[0] <= rd_en;
      wr_a_p[0]   <= rd_addr_a;
      wr_b_p[0]   <= rd_addr_b;
      for (int i = 1; i < LAT; i++) begin
        wr_vld_p[i] <= wr_vld_p[i-1];
        wr_a_p[i]   <= wr_a_p[i-1];
        wr_b_p[i]   <= wr_b_p[i-1];
      end
    end
  end

  assign wr_en     = wr_vld_p[LAT-1];
  assign wr_addr_a = wr_a_p[LAT-1];
  assign wr_addr_b = wr_b_p[LAT-1];

endmodule

// File: tb/tb_bfly_seq.sv
// Testbench for bfly_seq: default 8-point instance plus a 16-point LAT=3
// instance, driven with directed scenarios and hand-computed expectations.
`timescale 1ns/1ps
module tb_bfly_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance (LOG2PTS=3, LAT=2)
  logic       start = 1'b0, hold = 1'b0;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_idx;

  // large instance (LOG2PTS=4, LAT=3)
  logic       start_b = 1'b0, hold_b = 1'b0;
  logic       busy_b, done_b, rd_en_b, wr_en_b;
  logic [3:0] stage_b, rd_a_b, rd_b_b, wr_a_b, wr_b_b;
  logic [2:0] tw_b;

  int checks = 0;
  int errors = 0;

  bfly_seq #(.N(4), .LOG2PTS(3), .LAT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  bfly_seq #(.N(4), .LOG2PTS(4), .LAT(3)) u_big (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold_b),
    .busy(busy_b), .done(done_b), .stage(stage_b),
    .rd_en(rd_en_b), .rd_addr_a(rd_a_b), .rd_addr_b(rd_b_b), .tw_idx(tw_b),
    .wr_en(wr_en_b), .wr_addr_a(wr_a_b), .wr_addr_b(wr_b_b)
  );

  // Hand-derived read sequence for the 8-point transform.
  int exp_a [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int exp_t [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
  int iss_def  [12] = '{1, 2, 3, 4,  7, 8, 9, 10,  13, 14, 15, 16};
  int iss_hold [12] = '{1, 4, 5, 6,  9, 10, 11, 12,  15, 16, 17, 18};

  // Run one transform on the default instance, checking every output each cycle.
  task automatic check_run(input string tag, input int iss [12], input int done_c,
                           input int h_lo, input int h_hi,
                           input int s_a, input int s_b, input int s_c,
                           input bit pre_started);
    logic [8:0] got_rd, want_rd;
    logic [6:0] got_wr, want_wr;
    logic [1:0] got_ctl, want_ctl;
    int ja, jw;
    if (!pre_started) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 1; c <= done_c + 1; c++) begin
      hold  = (c >= h_lo) && (c <= h_hi);
      start = (c == s_a) || (c == s_b) || (c == s_c);
      @(posedge clk); #1;
      ja = -1;
      jw = -1;
      for (int j = 0; j < 12; j++) begin
        if (iss[j] == c) ja = j;
        if (iss[j] + 2 == c) jw = j;
      end
      want_rd = (ja >= 0) ? {1'b1, 3'(exp_a[ja]), 3'(exp_b[ja]), 2'(exp_t[ja])} : 9'h0;
      want_wr = (jw >= 0) ? {1'b1, 3'(exp_a[jw]), 3'(exp_b[jw])} : 7'h0;
      want_ctl = {(c >= 1) && (c <= done_c - 1), c == done_c};
      got_rd  = {rd_en, rd_addr_a, rd_addr_b, tw_idx};
      got_wr  = {wr_en, wr_addr_a, wr_addr_b};
      got_ctl = {busy, done};
      checks++;
      if (got_rd !== want_rd) begin
        errors++;
        $display("FAIL %s_rd cycle %0d: got %h expected %h", tag, c, got_rd, want_rd);
      end
      checks++;
      if (got_wr !== want_wr) begin
        errors++;
        $display("FAIL %s_wr cycle %0d: got %h expected %h", tag, c, got_wr, want_wr);
      end
      checks++;
      if (got_ctl !== want_ctl) begin
        errors++;
        $display("FAIL %s_busy_done cycle %0d: got %b expected %b", tag, c, got_ctl, want_ctl);
      end
      if (ja >= 0) begin
        checks++;
        if (stage !== 3'(ja / 4)) begin
          errors++;
          $display("FAIL %s_stage cycle %0d: got %0d expected %0d", tag, c, stage, ja / 4);
        end
      end
    end
    hold  = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [17:0] got_a;
    logic [23:0] got_b;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    got_a = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a};
    got_b = {busy_b, done_b, stage_b, rd_en_b, rd_a_b, rd_b_b, tw_b, wr_en_b, wr_a_b};
    checks++;
    if (got_a !== 18'h0 || wr_addr_b !== 3'h0) begin
      errors++;
      $display("FAIL reset_default: got %h/%h expected 0", got_a, wr_addr_b);
    end
    checks++;
    if (got_b !== 24'h0 || wr_b_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_big: got %h/%h expected 0", got_b, wr_b_b);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_default();
    check_run("default", iss_def, 19, 0, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic test_hold();
    check_run("hold", iss_hold, 21, 2, 3, -1, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // start in a busy cycle and in the DONE cycle are ignored; cycle 20 restarts
    check_run("restart", iss_def, 19, 0, -1, 8, 19, 20, 1'b0);
    check_run("rerun", iss_def, 19, 0, -1, -1, -1, -1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if ({rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr_a, wr_addr_b} !== {1'b1, 3'd4, 3'd6, 1'b1, 3'd0, 3'd2}) begin
      errors++;
      $display("FAIL midrst_pre cycle 9: got %b%h%h %b%h%h expected 1 4 6 1 0 2",
               rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr_a, wr_addr_b);
    end
    #2 rst = 1'b1;
    #1;
    got = {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en};
    checks++;
    if (got !== 16'h0 || wr_addr_a !== 3'h0 || wr_addr_b !== 3'h0) begin
      errors++;
      $display("FAIL midrst_async: got %h %h %h expected 0", got, wr_addr_a, wr_addr_b);
    end
    #1 rst = 1'b0;
    for (int c = 10; c < 24; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({wr_en, rd_en, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL midrst_quiet cycle %0d: got wr/rd/busy/done %b expected 0000",
                 c, {wr_en, rd_en, busy, done});
      end
    end
    check_run("after_rst", iss_def, 19, 0, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic test_big();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      @(posedge clk); #1;
      if (c == 34) begin
        checks++;
        if ({rd_en_b, rd_a_b, rd_b_b, tw_b, stage_b} !== {1'b1, 4'd0, 4'd8, 3'd0, 4'd3}) begin
          errors++;
          $display("FAIL big_s3k0 cycle 34: got %b %0d %0d %0d stage %0d expected 1 0 8 0 stage 3",
                   rd_en_b, rd_a_b, rd_b_b, tw_b, stage_b);
        end
      end
      if (c == 39) begin
        checks++;
        if ({rd_en_b, rd_a_b, rd_b_b, tw_b, stage_b} !== {1'b1, 4'd5, 4'd13, 3'd5, 4'd3}) begin
          errors++;
          $display("FAIL big_s3k5 cycle 39: got %b %0d %0d %0d stage %0d expected 1 5 13 5 stage 3",
                   rd_en_b, rd_a_b, rd_b_b, tw_b, stage_b);
        end
      end
      if (c == 42) begin
        checks++;
        if ({wr_en_b, wr_a_b, wr_b_b} !== {1'b1, 4'd5, 4'd13}) begin
          errors++;
          $display("FAIL big_wr cycle 42: got %b %0d %0d expected 1 5 13",
                   wr_en_b, wr_a_b, wr_b_b);
        end
      end
      if (c >= 43) begin
        checks++;
        if ({busy_b, done_b} !== {c <= 44, c == 45}) begin
          errors++;
          $display("FAIL big_busy_done cycle %0d: got %b expected %b",
                   c, {busy_b, done_b}, {c <= 44, c == 45});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    repeat (2) @(posedge clk);
    #1;
    test_hold();
    repeat (2) @(posedge clk);
    #1;
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    test_big();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
